// File: rtl/cnl_chk_pkg.sv
// Shared types and constants for the CNN result checker: FSM states, LFSR
// constants and the coordinate triple used to report mismatches.
package cnl_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } chk_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int CRD_ROW_W   = 10;
  localparam int CRD_DEPTH_W = 8;

  typedef struct packed {
    logic [CRD_ROW_W-1:0]   row;
    logic [CRD_ROW_W-1:0]   col;
    logic [CRD_DEPTH_W-1:0] depth;
  } coord_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cnl_chk_exp_ram.sv
// Expected-value RAM: one write port, one registered read port (1-cycle latency).
module cnl_chk_exp_ram #(
  parameter int C_DATA_WIDTH     = 16,
  parameter int C_EXP_ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [C_EXP_ADDR_WIDTH-1:0] wr_addr,
  input  logic [C_DATA_WIDTH-1:0]     wr_data,
  input  logic                        rd_en,
  input  logic [C_EXP_ADDR_WIDTH-1:0] rd_addr,
  output logic [C_DATA_WIDTH-1:0]     rd_data
);

  logic [C_DATA_WIDTH-1:0] mem [2**C_EXP_ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cnl_result_checker.sv
// Result scoreboard for the CNN layer accelerator quad: compares accepted
// result beats against a preloaded expected RAM. Optional: CNL_CHK_BACKPRESSURE_EN.
module cnl_result_checker
  import cnl_chk_pkg::*;
#(
  parameter int C_DATA_WIDTH     = 16,
  parameter int C_ROW_WIDTH      = 10,
  parameter int C_DEPTH_WIDTH    = 8,
  parameter int C_EXP_ADDR_WIDTH = 16,
  parameter int C_TOL            = 0,
  parameter int C_TIMEOUT        = 4096
) (
  input  logic                        clk_if,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [C_ROW_WIDTH-1:0]      cfg_num_output_rows,
  input  logic [C_ROW_WIDTH-1:0]      cfg_num_output_cols,
  input  logic [C_DEPTH_WIDTH-1:0]    cfg_num_kernels,
  input  logic                        exp_wr_en,
  input  logic [C_EXP_ADDR_WIDTH-1:0] exp_wr_addr,
  input  logic [C_DATA_WIDTH-1:0]     exp_wr_data,
  input  logic                        result_valid,
  output logic                        result_accept,
  input  logic [C_DATA_WIDTH-1:0]     result_data,
  output logic [C_ROW_WIDTH-1:0]      output_row,
  output logic [C_ROW_WIDTH-1:0]      output_col,
  output logic [C_DEPTH_WIDTH-1:0]    output_depth,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic                        cfg_err,
  output logic                        extra_beat,
  output logic [31:0]                 mismatch_count,
  output logic [C_ROW_WIDTH-1:0]      first_err_row,
  output logic [C_ROW_WIDTH-1:0]      first_err_col,
  output logic [C_DEPTH_WIDTH-1:0]    first_err_depth
);

  localparam int IDLE_W = $clog2(C_TIMEOUT + 1);
  localparam logic [C_ROW_WIDTH-1:0]   ROW_ONE   = C_ROW_WIDTH'(1);
  localparam logic [C_DEPTH_WIDTH-1:0] DEPTH_ONE = C_DEPTH_WIDTH'(1);
  localparam logic [IDLE_W-1:0]        IDLE_LAST = IDLE_W'(C_TIMEOUT - 1);
  localparam logic [C_DATA_WIDTH:0]    TOL_V     = (C_DATA_WIDTH + 1)'(C_TOL);

  chk_state_e state_q, state_d;

  logic [C_ROW_WIDTH-1:0]      rows_q, cols_q, row_q, col_q;
  logic [C_DEPTH_WIDTH-1:0]    kern_q, depth_q;
  logic [C_EXP_ADDR_WIDTH-1:0] addr_q;
  logic [C_DATA_WIDTH-1:0]     res_q, exp_q;
  logic                        cmp_vld_q;
  coord_t                      cmp_crd_q, first_crd_q;
  logic                        first_seen_q;
  logic [IDLE_W-1:0]           idle_q;
  logic                        timeout_q, cfg_err_q, extra_q;
  logic [31:0]                 mis_q, mis_d;

  logic stall, acc, run_acc, done_acc, last_beat, idle_tick, idle_exp;
  logic cfg_take, cfg_ok, cfg_go;
  logic signed [C_DATA_WIDTH:0] diff;
  logic [C_DATA_WIDTH:0]        mag;
  logic                         cmp_mis;
  logic [1:0]                   inc;
  logic [32:0]                  sum;

`ifdef CNL_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst)                lfsr_q <= LFSR_SEED;
    else if (state_q == RUN) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall = (state_q == RUN) && (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign result_accept = ((state_q == RUN) && !stall) || (state_q == DONE);
  assign acc       = result_valid && result_accept;
  assign run_acc   = acc && (state_q == RUN);
  assign done_acc  = acc && (state_q == DONE);
  assign last_beat = (row_q == rows_q - ROW_ONE) && (col_q == cols_q - ROW_ONE) &&
                     (depth_q == kern_q - DEPTH_ONE);
  // Stalled cycles are not idle: the checker, not the source, held the stream.
  assign idle_tick = (state_q == RUN) && result_accept && !result_valid;
  assign idle_exp  = idle_tick && (idle_q == IDLE_LAST);
  assign cfg_take  = cfg_valid && ((state_q == IDLE) || (state_q == DONE));
  assign cfg_ok    = (cfg_num_output_rows != '0) && (cfg_num_output_cols != '0) &&
                     (cfg_num_kernels != '0);
  assign cfg_go    = cfg_take && cfg_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_go) state_d = RUN;
      RUN: begin
        if (run_acc && last_beat) state_d = DRAIN;
        else if (idle_exp)        state_d = DONE;
      end
      DRAIN:   state_d = DONE;
      DONE:    if (cfg_take) state_d = cfg_ok ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  cnl_chk_exp_ram #(
    .C_DATA_WIDTH    (C_DATA_WIDTH),
    .C_EXP_ADDR_WIDTH(C_EXP_ADDR_WIDTH)
  ) u_exp_ram (
    .clk    (clk_if),
    .wr_en  (exp_wr_en && (state_q == IDLE)),
    .wr_addr(exp_wr_addr),
    .wr_data(exp_wr_data),
    .rd_en  (run_acc),
    .rd_addr(addr_q),
    .rd_data(exp_q)
  );

  assign diff    = $signed({res_q[C_DATA_WIDTH-1], res_q}) - $signed({exp_q[C_DATA_WIDTH-1], exp_q});
  assign mag     = diff[C_DATA_WIDTH] ? -diff : diff;
  assign cmp_mis = cmp_vld_q && (mag > TOL_V);
  assign inc     = {1'b0, cmp_mis} + {1'b0, done_acc};
  assign sum     = {1'b0, mis_q} + 33'(inc);
  assign mis_d   = sum[32] ? '1 : sum[31:0];

  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      kern_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      depth_q      <= '0;
      addr_q       <= '0;
      res_q        <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_crd_q    <= '0;
      first_crd_q  <= '0;
      first_seen_q <= 1'b0;
      idle_q       <= '0;
      timeout_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      extra_q      <= 1'b0;
      mis_q        <= '0;
    end else begin
      state_q   <= state_d;
      cmp_vld_q <= run_acc;
      if (cfg_go) begin
        rows_q       <= cfg_num_output_rows;
        cols_q       <= cfg_num_output_cols;
        kern_q       <= cfg_num_kernels;
        row_q        <= '0;
        col_q        <= '0;
        depth_q      <= '0;
        addr_q       <= '0;
        first_crd_q  <= '0;
        first_seen_q <= 1'b0;
        idle_q       <= '0;
        timeout_q    <= 1'b0;
        cfg_err_q    <= 1'b0;
        extra_q      <= 1'b0;
        mis_q        <= '0;
      end else begin
        if (cfg_take) cfg_err_q <= 1'b1;
        mis_q <= mis_d;
        if (cmp_mis && !first_seen_q) begin
          first_crd_q  <= cmp_crd_q;
          first_seen_q <= 1'b1;
        end
        if (done_acc) extra_q <= 1'b1;
        if (idle_exp) timeout_q <= 1'b1;
        if (run_acc)        idle_q <= '0;
        else if (idle_tick) idle_q <= idle_q + IDLE_W'(1);
        if (run_acc) begin
          res_q     <= result_data;
          cmp_crd_q <= '{row: CRD_ROW_W'(row_q), col: CRD_ROW_W'(col_q),
                         depth: CRD_DEPTH_W'(depth_q)};
          // Beats arrive in address order, so the RAM address is a plain beat counter.
          addr_q    <= addr_q + C_EXP_ADDR_WIDTH'(1);
          if (depth_q == kern_q - DEPTH_ONE) begin
            depth_q <= '0;
            if (col_q == cols_q - ROW_ONE) begin
              col_q <= '0;
              row_q <= row_q + ROW_ONE;
            end else begin
              col_q <= col_q + ROW_ONE;
            end
          end else begin
            depth_q <= depth_q + DEPTH_ONE;
          end
        end
      end
    end
  end

  assign cfg_ready       = (state_q == IDLE);
  assign done            = (state_q == DONE);
  assign pass            = done && (mis_q == '0) && !timeout_q && !extra_q;
  assign timeout         = timeout_q;
  assign cfg_err         = cfg_err_q;
  assign extra_beat      = extra_q;
  assign mismatch_count  = mis_q;
  assign output_row      = row_q;
  assign output_col      = col_q;
  assign output_depth    = depth_q;
  assign first_err_row   = C_ROW_WIDTH'(first_crd_q.row);
  assign first_err_col   = C_ROW_WIDTH'(first_crd_q.col);
  assign first_err_depth = C_DEPTH_WIDTH'(first_crd_q.depth);

endmodule

// File: tb/tb_cnl_result_checker.sv
// Self-checking bench for cnl_result_checker with a behavioural scoreboard model.
module tb_cnl_result_checker;
  localparam int DW  = 16;
  localparam int RW  = 10;
  localparam int DPW = 8;
  localparam int AW  = 16;
  localparam int TOL = 2;
  localparam int TMO = 200;

  logic           clk_if = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [RW-1:0]  cfg_num_output_rows = '0;
  logic [RW-1:0]  cfg_num_output_cols = '0;
  logic [DPW-1:0] cfg_num_kernels = '0;
  logic           exp_wr_en = 1'b0;
  logic [AW-1:0]  exp_wr_addr = '0;
  logic [DW-1:0]  exp_wr_data = '0;
  logic           result_valid = 1'b0;
  logic           result_accept;
  logic [DW-1:0]  result_data = '0;
  logic [RW-1:0]  output_row, output_col, first_err_row, first_err_col;
  logic [DPW-1:0] output_depth, first_err_depth;
  logic           done, pass, timeout, cfg_err, extra_beat;
  logic [31:0]    mismatch_count;

  always #5 clk_if = ~clk_if;

  cnl_result_checker #(
    .C_DATA_WIDTH(DW), .C_ROW_WIDTH(RW), .C_DEPTH_WIDTH(DPW),
    .C_EXP_ADDR_WIDTH(AW), .C_TOL(TOL), .C_TIMEOUT(TMO)
  ) dut (
    .clk_if(clk_if), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_output_rows(cfg_num_output_rows), .cfg_num_output_cols(cfg_num_output_cols),
    .cfg_num_kernels(cfg_num_kernels), .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr),
    .exp_wr_data(exp_wr_data), .result_valid(result_valid), .result_accept(result_accept),
    .result_data(result_data), .output_row(output_row), .output_col(output_col),
    .output_depth(output_depth), .done(done), .pass(pass), .timeout(timeout),
    .cfg_err(cfg_err), .extra_beat(extra_beat), .mismatch_count(mismatch_count),
    .first_err_row(first_err_row), .first_err_col(first_err_col),
    .first_err_depth(first_err_depth)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  logic signed [DW-1:0] exp_arr [0:1023];
  logic signed [DW-1:0] res_arr [0:1023];
  int exp_mis, exp_row, exp_col, exp_dep;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_if);
    rst = 1'b0; cfg_valid = 1'b0; exp_wr_en = 1'b0; result_valid = 1'b0;
    repeat (2) @(negedge clk_if);
    rst = 1'b1;
    @(negedge clk_if);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      exp_wr_en = 1'b1; exp_wr_addr = AW'(i); exp_wr_data = exp_arr[i];
      @(negedge clk_if);
    end
    exp_wr_en = 1'b0;
  endtask

  task automatic configure(input int r, input int c, input int k);
    cfg_valid = 1'b1;
    cfg_num_output_rows = RW'(r); cfg_num_output_cols = RW'(c); cfg_num_kernels = DPW'(k);
    @(negedge clk_if);
    cfg_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    bit ok = 0;
    result_valid = 1'b1; result_data = d;
    for (int t = 0; t < 64 && !ok; t++) begin
      #1;
      if (result_accept) ok = 1;
      else stall_cnt++;
      @(negedge clk_if);
    end
    if (!ok) check("beat_accept_wait", 0, 1);
  endtask

  task automatic wait_done(input int bound);
    for (int t = 0; t < bound && !done; t++) @(negedge clk_if);
    check("done_reached", done, 1);
  endtask

  // Scoreboard: beat index i maps to (row, col, depth) with depth fastest.
  task automatic model(input int n, input int c, input int k);
    int first = -1;
    exp_mis = 0;
    for (int i = 0; i < n; i++) begin
      int d = int'(res_arr[i]) - int'(exp_arr[i]);
      if (d < 0) d = -d;
      if (d > TOL) begin
        exp_mis++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) begin exp_row = 0; exp_col = 0; exp_dep = 0; end
    else begin exp_dep = first % k; exp_col = (first / k) % c; exp_row = first / (k * c); end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_pass"}, pass, (exp_mis == 0) ? 1 : 0);
    check({tag, "_mismatch_count"}, mismatch_count, exp_mis);
    check({tag, "_first_err_row"}, first_err_row, exp_row);
    check({tag, "_first_err_col"}, first_err_col, exp_col);
    check({tag, "_first_err_depth"}, first_err_depth, exp_dep);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_extra_beat"}, extra_beat, 0);
  endtask

  task automatic run_case(input string tag, input int r, input int c, input int k, input int mid);
    int n = r * c * k;
    do_reset();
    load(n);
    configure(r, c, k);
    for (int i = 0; i < n; i++) begin
      if (i == mid) begin
        check({tag, "_out_depth"}, output_depth, mid % k);
        check({tag, "_out_col"}, output_col, (mid / k) % c);
        check({tag, "_out_row"}, output_row, mid / (k * c));
      end
      send_beat(res_arr[i]);
    end
    result_valid = 1'b0;
    wait_done(20);
    model(n, c, k);
    check_results(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_result_accept"}, result_accept, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_extra_beat"}, extra_beat, 0);
    check({tag, "_mismatch_count"}, mismatch_count, 0);
    check({tag, "_coords"}, {output_row, output_col, output_depth}, 0);
    check({tag, "_first_err"}, {first_err_row, first_err_col, first_err_depth}, 0);
  endtask

  function automatic logic signed [DW-1:0] rnd_val();
    return DW'($urandom_range(0, 32000)) - DW'(16000);
  endfunction

  function automatic logic signed [DW-1:0] jitter(input logic signed [DW-1:0] v, input int lim);
    int j = int'($urandom_range(0, 2 * lim)) - lim;
    return v + DW'(j);
  endfunction

  initial begin
    logic signed [DW-1:0] base;
    // reset state
    do_reset();
    check_reset_values("reset");

    // exact match, 18x18x1 ramp
    base = DW'($urandom_range(0, 2000)) - DW'(1000);
    for (int i = 0; i < 324; i++) begin exp_arr[i] = base + DW'(i); res_arr[i] = exp_arr[i]; end
    run_case("exact", 18, 18, 1, 100);

    // single error at (2,1,2) in 4x4x3, other beats within tolerance
    for (int i = 0; i < 48; i++) begin exp_arr[i] = rnd_val(); res_arr[i] = jitter(exp_arr[i], TOL); end
    res_arr[(2 * 4 + 1) * 3 + 2] = exp_arr[(2 * 4 + 1) * 3 + 2] + DW'(5);
    run_case("single_err", 4, 4, 3, 7);

    // tolerance edge: every beat off by exactly +-2, (0,0,0) off by 3
    for (int i = 0; i < 24; i++) begin
      exp_arr[i] = rnd_val();
      res_arr[i] = exp_arr[i] + (($urandom_range(0, 1) == 1) ? DW'(2) : -DW'(2));
    end
    res_arr[0] = exp_arr[0] - DW'(3);
    run_case("tolerance", 3, 4, 2, 5);

    // randomized geometry and deviations
    for (int t = 0; t < 3; t++) begin
      int r = int'($urandom_range(1, 4));
      int c = int'($urandom_range(1, 4));
      int k = int'($urandom_range(1, 4));
      for (int i = 0; i < r * c * k; i++) begin exp_arr[i] = rnd_val(); res_arr[i] = jitter(exp_arr[i], 4); end
      run_case($sformatf("random%0d", t), r, c, k, r * c * k - 1);
    end

    // timeout after 10 of 16 beats
    for (int i = 0; i < 16; i++) begin exp_arr[i] = rnd_val(); res_arr[i] = exp_arr[i]; end
    do_reset();
    load(16);
    configure(4, 4, 1);
    for (int i = 0; i < 10; i++) send_beat(res_arr[i]);
    result_valid = 1'b0;
    repeat (TMO - 2) @(negedge clk_if);
    check("timeout_not_early", timeout, 0);
    check("timeout_done_not_early", done, 0);
    wait_done(2 * TMO);
    check("timeout_flag", timeout, 1);
    check("timeout_pass", pass, 0);
    check("timeout_mismatch_count", mismatch_count, 0);

    // extra beat: 17 beats for 16 expected
    do_reset();
    load(16);
    configure(4, 4, 1);
    for (int i = 0; i < 17; i++) send_beat(res_arr[i % 16]);
    result_valid = 1'b0;
    @(negedge clk_if);
    check("extra_done", done, 1);
    check("extra_flag", extra_beat, 1);
    check("extra_mismatch_count", mismatch_count, 1);
    check("extra_pass", pass, 0);
    check("extra_first_err", {first_err_row, first_err_col, first_err_depth}, 0);

    // rejected configuration, then accepted one clears the flag
    do_reset();
    configure(3, 3, 0);
    check("cfg_err_set", cfg_err, 1);
    check("cfg_err_ready", cfg_ready, 1);
    check("cfg_err_accept", result_accept, 0);
    check("cfg_err_done", done, 0);
    configure(2, 2, 1);
    check("cfg_err_cleared", cfg_err, 0);
    check("cfg_ok_ready", cfg_ready, 0);

    // reset mid-run, then a clean run on the retained RAM contents
    do_reset();
    load(16);
    configure(4, 4, 1);
    for (int i = 0; i < 5; i++) send_beat(res_arr[i]);
    rst = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    result_valid = 1'b0;
    @(negedge clk_if);
    rst = 1'b1;
    @(negedge clk_if);
    configure(4, 4, 1);
    for (int i = 0; i < 16; i++) send_beat(res_arr[i]);
    result_valid = 1'b0;
    wait_done(20);
    model(16, 4, 1);
    check_results("after_reset");

`ifdef CNL_CHK_BACKPRESSURE_EN
    // back-pressure: 2x2x4 with valid held, stalls must appear
    for (int i = 0; i < 16; i++) begin exp_arr[i] = rnd_val(); res_arr[i] = exp_arr[i]; end
    stall_cnt = 0;
    run_case("backpressure", 2, 2, 4, 3);
    check("backpressure_stalls_seen", (stall_cnt > 0) ? 1 : 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cnl_result_checker.md
Name: cnl_result_checker

Overview:
- Synthesizable, parametrised result scoreboard for the CNN layer accelerator quad. It generalises the scenario-1 convolution-output check to N kernels, arbitrary output geometry, a tolerance window and an optional back-pressure pattern.
- Sits on the quad's result_valid/result_accept/result_data stream in the clk_if domain.
- Compares each accepted result against a preloaded expected-value RAM and reports pass/fail, the mismatch count and the coordinates of the first mismatch.

Parameters:
- C_DATA_WIDTH, 16, result and expected word width (signed two's complement).
- C_ROW_WIDTH, 10, width of row/col config and counters.
- C_DEPTH_WIDTH, 8, width of kernel-count config and depth counter.
- C_EXP_ADDR_WIDTH, 16, expected-RAM address width (2**W entries).
- C_TOL, 0, maximum allowed absolute difference |result - expected|.
- C_TIMEOUT, 4096, idle clk_if cycles in RUN before a timeout is declared.

Ports:
- clk_if  in  1  interface clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration strobe.
- cfg_ready  out  1  high only in IDLE.
- cfg_num_output_rows  in  C_ROW_WIDTH  output rows.
- cfg_num_output_cols  in  C_ROW_WIDTH  output columns.
- cfg_num_kernels  in  C_DEPTH_WIDTH  output depth (kernels).
- exp_wr_en  in  1  expected-RAM write enable; accepted in IDLE only.
- exp_wr_addr  in  C_EXP_ADDR_WIDTH  expected-RAM write address.
- exp_wr_data  in  C_DATA_WIDTH  expected value.
- result_valid  in  1  result beat valid.
- result_accept  out  1  checker ready for a result beat.
- result_data  in  C_DATA_WIDTH  result value.
- output_row  out  C_ROW_WIDTH  row of the next expected beat.
- output_col  out  C_ROW_WIDTH  column of the next expected beat.
- output_depth  out  C_DEPTH_WIDTH  kernel of the next expected beat.
- done  out  1  check finished; sticky until the next cfg.
- pass  out  1  valid when done is high.
- timeout  out  1  sticky timeout flag.
- cfg_err  out  1  sticky flag: a configuration was rejected.
- extra_beat  out  1  sticky flag: a beat arrived after the last expected beat.
- mismatch_count  out  32  mismatches; saturates at 2**32-1.
- first_err_row  out  C_ROW_WIDTH  row of the first mismatch.
- first_err_col  out  C_ROW_WIDTH  column of the first mismatch.
- first_err_depth  out  C_DEPTH_WIDTH  kernel of the first mismatch.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0 except cfg_ready=1.
  - Expected RAM contents are not cleared.
- A beat is accepted when result_valid && result_accept.
- Beat order: depth fastest, then column, then row. Expected address = (row*cols + col)*kernels + depth, truncated to C_EXP_ADDR_WIDTH.
- FSM states:
  - IDLE:
    - cfg_ready=1 and result_accept=0.
    - cfg_valid with any zero dimension sets cfg_err and stays in IDLE.
    - cfg_valid with all dimensions nonzero: latch the configuration; clear done, pass, timeout, extra_beat, cfg_err, mismatch_count, first_err_*; zero the counters; go to RUN.
  - RUN:
    - result_accept=1 (unless the optional feature gates it).
    - On each accepted beat: capture result_data and issue the expected-RAM read (1-cycle latency).
    - Compare in the next cycle (CMP stage, pipelined, back-to-back beats supported).
    - A mismatch is |result - expected| > C_TOL, computed at C_DATA_WIDTH+1 bits signed.
    - First mismatch latches its coordinates and is never overwritten.
    - Counters advance on each accept: depth wraps at kernels-1 and increments col; col wraps at cols-1 and increments row.
    - Accepting the last beat (row=rows-1, col=cols-1, depth=kernels-1) moves to DRAIN.
    - An idle counter resets on every accept. Reaching C_TIMEOUT sets timeout and goes to DONE.
  - DRAIN: one cycle; the final compare retires; result_accept=0; then go to DONE.
  - DONE:
    - done=1 and pass = (mismatch_count==0) && !timeout && !extra_beat.
    - result_accept=1 so the stream drains. Any accepted beat sets extra_beat, increments mismatch_count and does not touch first_err_*.
    - cfg_ready=0. The next run starts only after reset or a cfg_valid pulse; cfg_valid in DONE behaves as in IDLE.
- cfg_valid and exp_wr_en are ignored in RUN and DRAIN.
- Simultaneous timeout expiry and accept in the same cycle: the accept wins and the idle counter resets.
- Reset mid-run: all flags and counters clear; return to IDLE.

Optional Feature:
- Macro CNL_CHK_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; advances every cycle in RUN) gates result_accept in RUN.
  - result_accept is deasserted when LFSR[1:0]==2'b00, giving roughly 25% stall.
  - Stall cycles do not advance the idle counter.
- Undefined: result_accept is constant 1 in RUN and DONE; no LFSR is instantiated.

Decomposition:
- Package cnl_chk_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - the LFSR seed and tap constants;
  - a typedef for the coordinate triple {row, col, depth}.
- Sub-module cnl_chk_exp_ram: simple dual-port RAM (write port, registered read port, 1-cycle read latency), parametrised by C_DATA_WIDTH and C_EXP_ADDR_WIDTH.

Test Plan:
- Exact match: rows=18, cols=18, kernels=1, RAM preloaded with a ramp, identical stream → done=1, pass=1, mismatch_count=0 after 324 beats.
- Single error: rows=4, cols=4, kernels=3; beat at (2,1,2) off by +5 with C_TOL=0 → mismatch_count=1, first_err=(2,1,2), pass=0.
- Tolerance: C_TOL=2; every beat off by ±2, one beat off by 3 at (0,0,0) → mismatch_count=1.
- Timeout and extra beat:
  - Stop the stream after 10 of 16 beats → timeout=1 after C_TIMEOUT cycles, pass=0.
  - Separate run: send 17 beats for 16 expected → extra_beat=1, mismatch_count=1.
- Config and reset:
  - cfg with kernels=0 → cfg_err=1, state stays IDLE, cfg_ready=1.
  - Assert rst mid-RUN → all outputs at reset values; a new cfg and a clean run then pass.
- With CNL_CHK_BACKPRESSURE_EN: 2x2x4 run with result_valid held high → result_accept has stall cycles, all 16 beats are checked, pass=1.
